// File: rtl/sys_bridge_n_pkg.sv
// Shared definitions for the Pr*-bus to device bridge: access codes, FSM
// states, the default IM/DM/timer/UART address windows and a byte-lane helper.
package sys_bridge_n_pkg;

    localparam logic RW_R = 1'b0;
    localparam logic RW_W = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [31:0] DM_BASE   = 32'h9000_0000;
    localparam logic [31:0] DM_MASK   = 32'hFFFF_0000;
    localparam logic [31:0] IM_BASE   = 32'hBFC0_0000;
    localparam logic [31:0] IM_MASK   = 32'hFFFF_C000;
    localparam logic [31:0] TMR_BASE  = 32'h0000_7F00;
    localparam logic [31:0] TMR_MASK  = 32'hFFFF_FFF0;
    localparam logic [31:0] UART_BASE = 32'h0000_7F10;
    localparam logic [31:0] UART_MASK = 32'hFFFF_FFF0;

    // Channel 0 occupies the most significant word of the packed tables.
    localparam logic [127:0] DEFAULT_BASE = {DM_BASE, IM_BASE, TMR_BASE, UART_BASE};
    localparam logic [127:0] DEFAULT_MASK = {DM_MASK, IM_MASK, TMR_MASK, UART_MASK};

    function automatic logic [31:0] be_to_mask(input logic [3:0] be);
        logic [31:0] mask;
        for (int i = 0; i < 4; i++) begin
            mask[8*i +: 8] = {8{be[i]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/sys_bridge_decode.sv
// Address decoder: matches a byte address against NUM_DEV base/mask windows
// and returns a one-hot select (lowest matching channel) plus a hit flag.
module sys_bridge_decode
    import sys_bridge_n_pkg::*;
#(
    parameter int                    NUM_DEV  = 4,
    parameter logic [32*NUM_DEV-1:0] DEV_BASE = DEFAULT_BASE,
    parameter logic [32*NUM_DEV-1:0] DEV_MASK = DEFAULT_MASK
) (
    input  logic [31:0]        addr,
    output logic [NUM_DEV-1:0] sel,
    output logic               hit
);

    logic found;

    always_comb begin
        sel   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_DEV; i++) begin
            if (!found &&
                ((addr & DEV_MASK[32*(NUM_DEV-1-i) +: 32]) == DEV_BASE[32*(NUM_DEV-1-i) +: 32])) begin
                sel[i] = 1'b1;
                found  = 1'b1;
            end
        end
        hit = found;
    end

endmodule

// File: rtl/sys_bridge_n.sv
// Processor-to-device bridge: decodes a Pr* request onto one of NUM_DEV
// strobe/ack channels, one transaction at a time, with timeout and error return.
module sys_bridge_n
    import sys_bridge_n_pkg::*;
#(
    parameter int                    NUM_DEV  = 4,
    parameter int                    DEV_AW   = 13,
    parameter logic [32*NUM_DEV-1:0] DEV_BASE = DEFAULT_BASE,
    parameter logic [32*NUM_DEV-1:0] DEV_MASK = DEFAULT_MASK,
    parameter int                    TIMEOUT  = 15
) (
    input  logic                    PClk,
    input  logic                    Reset,
    input  logic [29:0]             PrA,
    input  logic [3:0]              PrBE,
    input  logic [31:0]             PrWData,
    input  logic                    PrReq,
    input  logic                    PrRW,
    output logic [31:0]             PrRData,
    output logic                    PrReady,
    output logic                    PrErr,
    output logic [DEV_AW-1:0]       DEV_ADR,
    output logic [31:0]             DEV_DAT_O,
    output logic [3:0]              DEV_BE,
    output logic                    DEV_WE,
    output logic [NUM_DEV-1:0]      DEV_STB,
    input  logic [NUM_DEV-1:0]      DEV_ACK,
    input  logic [32*NUM_DEV-1:0]   DEV_DAT_I
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    state_t              state_q, state_d;
    logic [NUM_DEV-1:0]  stb_q, stb_d;
    logic                we_q, we_d;
    logic [DEV_AW-1:0]   adr_q, adr_d;
    logic [31:0]         dat_o_q, dat_o_d;
    logic [3:0]          be_q, be_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                ready_q, ready_d;
    logic                err_q, err_d;

    logic [NUM_DEV-1:0]  dec_sel;
    logic                dec_hit;
    logic                ack_hit;
    logic [31:0]         rd_mux;

    sys_bridge_decode #(
        .NUM_DEV  (NUM_DEV),
        .DEV_BASE (DEV_BASE),
        .DEV_MASK (DEV_MASK)
    ) u_decode (
        .addr (({PrA, 2'b00})),
        .sel  (dec_sel),
        .hit  (dec_hit)
    );

    // The strobe is one-hot, so it doubles as the select for ack and read data.
    always_comb begin
        rd_mux  = '0;
        ack_hit = |(DEV_ACK & stb_q);
        for (int i = 0; i < NUM_DEV; i++) begin
            if (stb_q[i]) begin
                rd_mux = rd_mux | DEV_DAT_I[32*i +: 32];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        stb_d   = stb_q;
        we_d    = we_q;
        adr_d   = adr_q;
        dat_o_d = dat_o_q;
        be_d    = be_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        ready_d = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (PrReq) begin
                    adr_d   = PrA[DEV_AW-1:0];
                    dat_o_d = PrWData & be_to_mask(PrBE);
                    be_d    = PrBE;
                    cnt_d   = '0;
                    if (dec_hit) begin
                        stb_d   = dec_sel;
                        we_d    = (PrRW == RW_W);
                        state_d = ACCESS;
                    end else begin
                        rdata_d = '0;
                        ready_d = 1'b1;
                        err_d   = 1'b1;
                        state_d = RESP;
                    end
                end
            end

            ACCESS: begin
                // An acknowledge in the final allowed cycle still beats the timeout.
                if (ack_hit) begin
                    stb_d   = '0;
                    we_d    = 1'b0;
                    ready_d = 1'b1;
                    state_d = RESP;
                    if (we_q == RW_R) begin
                        rdata_d = rd_mux & be_to_mask(be_q);
                    end
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    stb_d   = '0;
                    we_d    = 1'b0;
                    ready_d = 1'b1;
                    err_d   = 1'b1;
                    state_d = RESP;
                    if (we_q == RW_R) begin
                        rdata_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                stb_d   = '0;
                we_d    = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge PClk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            stb_q   <= '0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            dat_o_q <= '0;
            be_q    <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            stb_q   <= stb_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            dat_o_q <= dat_o_d;
            be_q    <= be_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end

    assign PrRData   = rdata_q;
    assign PrReady   = ready_q;
    assign PrErr     = err_q;
    assign DEV_ADR   = adr_q;
    assign DEV_DAT_O = dat_o_q;
    assign DEV_BE    = be_q;
    assign DEV_WE    = we_q;
    assign DEV_STB   = stb_q;

endmodule

// File: tb/tb_sys_bridge_n.sv
// Self-checking bench for sys_bridge_n: expected responses are queued by a
// small bridge model when each request is issued and compared on PrReady.
module tb_sys_bridge_n;

    localparam int TIMEOUT = 15;
    localparam int MAX_CYC = 40;

    logic         PClk;
    logic         Reset;
    logic [29:0]  PrA;
    logic [3:0]   PrBE;
    logic [31:0]  PrWData;
    logic         PrReq;
    logic         PrRW;
    logic [31:0]  PrRData;
    logic         PrReady;
    logic         PrErr;
    logic [12:0]  DEV_ADR;
    logic [31:0]  DEV_DAT_O;
    logic [3:0]   DEV_BE;
    logic         DEV_WE;
    logic [3:0]   DEV_STB;
    logic [3:0]   DEV_ACK;
    logic [127:0] DEV_DAT_I;

    sys_bridge_n #(
        .NUM_DEV (4),
        .DEV_AW  (13),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .PClk      (PClk),
        .Reset     (Reset),
        .PrA       (PrA),
        .PrBE      (PrBE),
        .PrWData   (PrWData),
        .PrReq     (PrReq),
        .PrRW      (PrRW),
        .PrRData   (PrRData),
        .PrReady   (PrReady),
        .PrErr     (PrErr),
        .DEV_ADR   (DEV_ADR),
        .DEV_DAT_O (DEV_DAT_O),
        .DEV_BE    (DEV_BE),
        .DEV_WE    (DEV_WE),
        .DEV_STB   (DEV_STB),
        .DEV_ACK   (DEV_ACK),
        .DEV_DAT_I (DEV_DAT_I)
    );

    initial PClk = 1'b0;
    always #5 PClk = ~PClk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          stb_cycles;
        logic [3:0]  stb;
        logic [12:0] adr;
        logic [31:0] dato;
        logic [3:0]  be;
        logic        we;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    int          vectors;
    int          miscompares;
    logic [31:0] model_rdata;

    int          obs_lat;
    int          obs_stb_cycles;
    logic        obs_ready;
    logic        obs_stable;
    logic [3:0]  obs_stb;
    logic        obs_we;
    logic [12:0] obs_adr;
    logic [31:0] obs_dato;
    logic [3:0]  obs_be;
    logic [31:0] obs_rdata;
    logic        obs_err;

    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) m[8*i +: 8] = be[i] ? 8'hFF : 8'h00;
        return m;
    endfunction

    // Reference model of one transaction; ch < 0 means unmapped, ack_wait < 0 never acks.
    task automatic push_expected(input logic [31:0] baddr, input logic [3:0] be, input logic [31:0] wd,
                                 input logic rw, input int ch, input int ack_wait, input logic [31:0] ddata);
        exp_t x;
        x.adr  = baddr[14:2];
        x.dato = wd & lane_mask(be);
        x.be   = be;
        x.we   = rw;
        x.stb  = (ch >= 0) ? (4'b0001 << ch) : 4'b0000;
        if (ch < 0) begin
            x.rdata = 32'h0; x.err = 1'b1; x.lat = 1; x.stb_cycles = 0;
        end else if (ack_wait < 0 || ack_wait >= TIMEOUT) begin
            x.rdata = rw ? model_rdata : 32'h0; x.err = 1'b1;
            x.lat = TIMEOUT + 1; x.stb_cycles = TIMEOUT;
        end else begin
            x.rdata = rw ? model_rdata : (ddata & lane_mask(be)); x.err = 1'b0;
            x.lat = ack_wait + 2; x.stb_cycles = ack_wait + 1;
        end
        model_rdata = x.rdata;
        sb.push_back(x);
    endtask

    // Drives one request, plays the device side and records what the bridge did.
    task automatic transact(input logic [31:0] baddr, input logic [3:0] be, input logic [31:0] wd,
                            input logic rw, input int ch, input int ack_wait, input logic [31:0] ddata,
                            input bit noisy);
        logic [3:0] sel_mask;
        int c;
        sel_mask = (ch >= 0) ? (4'b0001 << ch) : 4'b0000;
        obs_ready = 1'b0; obs_stable = 1'b1; obs_stb_cycles = 0; obs_lat = -1;
        obs_stb = '0; obs_we = 1'b0; obs_adr = '0; obs_dato = '0; obs_be = '0;
        obs_rdata = '0; obs_err = 1'b0;
        @(negedge PClk);
        PrA = baddr[31:2]; PrBE = be; PrWData = wd; PrRW = rw; PrReq = 1'b1;
        for (int i = 0; i < 4; i++) DEV_DAT_I[32*i +: 32] = (i == ch) ? ddata : ~ddata;
        @(negedge PClk);
        PrReq = 1'b0; PrA = ~PrA; PrBE = ~be; PrWData = ~wd; PrRW = ~rw;
        c = 1;
        while (!obs_ready && c <= MAX_CYC) begin
            if (PrReady) begin
                obs_ready = 1'b1; obs_lat = c; obs_rdata = PrRData; obs_err = PrErr;
            end
            if (DEV_STB != 4'b0000) begin
                if (obs_stb_cycles == 0) begin
                    obs_stb = DEV_STB; obs_we = DEV_WE; obs_adr = DEV_ADR;
                    obs_dato = DEV_DAT_O; obs_be = DEV_BE;
                end else if (DEV_STB !== obs_stb || DEV_WE !== obs_we || DEV_ADR !== obs_adr ||
                             DEV_DAT_O !== obs_dato || DEV_BE !== obs_be) begin
                    obs_stable = 1'b0;
                end
                if (obs_stb_cycles == ack_wait) DEV_ACK = sel_mask;
                else DEV_ACK = noisy ? ~sel_mask : 4'b0000;
                obs_stb_cycles++;
            end else begin
                DEV_ACK = 4'b0000;
            end
            if (!obs_ready) begin
                @(negedge PClk);
                c++;
            end
        end
        DEV_ACK = 4'b0000;
        if (!obs_ready) $display("[TB] FAIL handshake: no PrReady within %0d cycles", MAX_CYC);
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        PrA = '0; PrBE = '0; PrWData = '0; PrReq = 1'b0; PrRW = 1'b0;
        DEV_ACK = '0; DEV_DAT_I = '0;
        repeat (3) @(negedge PClk);
        vectors++; if (PrRData !== 32'h0)   begin miscompares++; $display("[TB] FAIL reset_rdata: got %h expected 0", PrRData); end
        vectors++; if (PrReady !== 1'b0)    begin miscompares++; $display("[TB] FAIL reset_ready: got %b expected 0", PrReady); end
        vectors++; if (PrErr !== 1'b0)      begin miscompares++; $display("[TB] FAIL reset_err: got %b expected 0", PrErr); end
        vectors++; if (DEV_STB !== 4'h0)    begin miscompares++; $display("[TB] FAIL reset_stb: got %b expected 0", DEV_STB); end
        vectors++; if (DEV_WE !== 1'b0)     begin miscompares++; $display("[TB] FAIL reset_we: got %b expected 0", DEV_WE); end
        vectors++; if (DEV_ADR !== 13'h0)   begin miscompares++; $display("[TB] FAIL reset_adr: got %h expected 0", DEV_ADR); end
        vectors++; if (DEV_DAT_O !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_dato: got %h expected 0", DEV_DAT_O); end
        vectors++; if (DEV_BE !== 4'h0)     begin miscompares++; $display("[TB] FAIL reset_be: got %b expected 0", DEV_BE); end
        Reset = 1'b0;
        model_rdata = 32'h0;
    endtask

    task automatic test_read_dm();
        push_expected(32'h9000_0010, 4'b1111, 32'h0, 1'b0, 0, 0, 32'hDEAD_BEEF);
        transact(32'h9000_0010, 4'b1111, 32'h0, 1'b0, 0, 0, 32'hDEAD_BEEF, 1'b0);
        e = sb.pop_front();
        vectors++; if (obs_rdata !== e.rdata) begin miscompares++; $display("[TB] FAIL dm_rdata: got %h expected %h", obs_rdata, e.rdata); end
        vectors++; if (obs_err !== e.err) begin miscompares++; $display("[TB] FAIL dm_err: got %b expected %b", obs_err, e.err); end
        vectors++; if (obs_lat != e.lat) begin miscompares++; $display("[TB] FAIL dm_latency: got %0d expected %0d", obs_lat, e.lat); end
        vectors++; if (obs_stb_cycles != e.stb_cycles) begin miscompares++; $display("[TB] FAIL dm_stb_cycles: got %0d expected %0d", obs_stb_cycles, e.stb_cycles); end
        vectors++; if (obs_stb !== e.stb) begin miscompares++; $display("[TB] FAIL dm_stb: got %b expected %b", obs_stb, e.stb); end
        vectors++; if (obs_adr !== e.adr) begin miscompares++; $display("[TB] FAIL dm_adr: got %h expected %h", obs_adr, e.adr); end
        vectors++; if (obs_we !== e.we) begin miscompares++; $display("[TB] FAIL dm_we: got %b expected %b", obs_we, e.we); end
        vectors++; if (obs_be !== e.be) begin miscompares++; $display("[TB] FAIL dm_be: got %b expected %b", obs_be, e.be); end
        @(negedge PClk);
        vectors++; if (PrReady !== 1'b0) begin miscompares++; $display("[TB] FAIL dm_ready_pulse: got %b expected 0", PrReady); end
    endtask

    task automatic test_byte_read_im();
        push_expected(32'hBFC0_0008, 4'b0100, 32'h0, 1'b0, 1, 0, 32'h1122_3344);
        transact(32'hBFC0_0008, 4'b0100, 32'h0, 1'b0, 1, 0, 32'h1122_3344, 1'b0);
        e = sb.pop_front();
        vectors++; if (obs_rdata !== e.rdata) begin miscompares++; $display("[TB] FAIL im_rdata: got %h expected %h", obs_rdata, e.rdata); end
        vectors++; if (obs_err !== e.err) begin miscompares++; $display("[TB] FAIL im_err: got %b expected %b", obs_err, e.err); end
        vectors++; if (obs_stb !== e.stb) begin miscompares++; $display("[TB] FAIL im_stb: got %b expected %b", obs_stb, e.stb); end
    endtask

    task automatic test_write_timer();
        push_expected(32'h0000_7F04, 4'b0011, 32'hA5A5_A5A5, 1'b1, 2, 3, 32'hFFFF_FFFF);
        transact(32'h0000_7F04, 4'b0011, 32'hA5A5_A5A5, 1'b1, 2, 3, 32'hFFFF_FFFF, 1'b1);
        e = sb.pop_front();
        vectors++; if (obs_rdata !== e.rdata) begin miscompares++; $display("[TB] FAIL tmr_rdata_held: got %h expected %h", obs_rdata, e.rdata); end
        vectors++; if (obs_err !== e.err) begin miscompares++; $display("[TB] FAIL tmr_err: got %b expected %b", obs_err, e.err); end
        vectors++; if (obs_lat != e.lat) begin miscompares++; $display("[TB] FAIL tmr_latency: got %0d expected %0d", obs_lat, e.lat); end
        vectors++; if (obs_stb_cycles != e.stb_cycles) begin miscompares++; $display("[TB] FAIL tmr_stb_cycles: got %0d expected %0d", obs_stb_cycles, e.stb_cycles); end
        vectors++; if (obs_stb !== e.stb) begin miscompares++; $display("[TB] FAIL tmr_stb: got %b expected %b", obs_stb, e.stb); end
        vectors++; if (obs_we !== e.we) begin miscompares++; $display("[TB] FAIL tmr_we: got %b expected %b", obs_we, e.we); end
        vectors++; if (obs_dato !== e.dato) begin miscompares++; $display("[TB] FAIL tmr_dato: got %h expected %h", obs_dato, e.dato); end
        vectors++; if (obs_stable !== 1'b1) begin miscompares++; $display("[TB] FAIL tmr_stable: got %b expected 1", obs_stable); end
        vectors++; if (DEV_WE !== 1'b0) begin miscompares++; $display("[TB] FAIL tmr_we_idle: got %b expected 0", DEV_WE); end
    endtask

    task automatic test_unmapped();
        push_expected(32'h1234_5678, 4'b1111, 32'h0, 1'b0, -1, 0, 32'h5555_AAAA);
        transact(32'h1234_5678, 4'b1111, 32'h0, 1'b0, -1, 0, 32'h5555_AAAA, 1'b0);
        e = sb.pop_front();
        vectors++; if (obs_rdata !== e.rdata) begin miscompares++; $display("[TB] FAIL unmap_rdata: got %h expected %h", obs_rdata, e.rdata); end
        vectors++; if (obs_err !== e.err) begin miscompares++; $display("[TB] FAIL unmap_err: got %b expected %b", obs_err, e.err); end
        vectors++; if (obs_lat != e.lat) begin miscompares++; $display("[TB] FAIL unmap_latency: got %0d expected %0d", obs_lat, e.lat); end
        vectors++; if (obs_stb_cycles != e.stb_cycles) begin miscompares++; $display("[TB] FAIL unmap_stb_cycles: got %0d expected %0d", obs_stb_cycles, e.stb_cycles); end
        @(negedge PClk);
        vectors++; if (PrErr !== 1'b0) begin miscompares++; $display("[TB] FAIL unmap_err_clear: got %b expected 0", PrErr); end
    endtask

    task automatic test_timeout();
        logic late_bad;
        push_expected(32'h0000_7F14, 4'b1111, 32'h0, 1'b0, 3, -1, 32'hCAFE_F00D);
        transact(32'h0000_7F14, 4'b1111, 32'h0, 1'b0, 3, -1, 32'hCAFE_F00D, 1'b0);
        e = sb.pop_front();
        vectors++; if (obs_err !== e.err) begin miscompares++; $display("[TB] FAIL to_err: got %b expected %b", obs_err, e.err); end
        vectors++; if (obs_rdata !== e.rdata) begin miscompares++; $display("[TB] FAIL to_rdata: got %h expected %h", obs_rdata, e.rdata); end
        vectors++; if (obs_lat != e.lat) begin miscompares++; $display("[TB] FAIL to_latency: got %0d expected %0d", obs_lat, e.lat); end
        vectors++; if (obs_stb_cycles != e.stb_cycles) begin miscompares++; $display("[TB] FAIL to_stb_cycles: got %0d expected %0d", obs_stb_cycles, e.stb_cycles); end
        late_bad = 1'b0;
        DEV_ACK = 4'b1000;
        repeat (3) begin
            @(negedge PClk);
            if (PrReady !== 1'b0 || DEV_STB !== 4'b0000) late_bad = 1'b1;
        end
        DEV_ACK = 4'b0000;
        vectors++; if (late_bad !== 1'b0) begin miscompares++; $display("[TB] FAIL to_late_ack: got %b expected 0", late_bad); end
    endtask

    task automatic test_ack_at_limit();
        push_expected(32'h0000_7F18, 4'b1001, 32'h0, 1'b0, 3, TIMEOUT - 1, 32'h8765_4321);
        transact(32'h0000_7F18, 4'b1001, 32'h0, 1'b0, 3, TIMEOUT - 1, 32'h8765_4321, 1'b0);
        e = sb.pop_front();
        vectors++; if (obs_err !== e.err) begin miscompares++; $display("[TB] FAIL limit_err: got %b expected %b", obs_err, e.err); end
        vectors++; if (obs_rdata !== e.rdata) begin miscompares++; $display("[TB] FAIL limit_rdata: got %h expected %h", obs_rdata, e.rdata); end
        vectors++; if (obs_lat != e.lat) begin miscompares++; $display("[TB] FAIL limit_latency: got %0d expected %0d", obs_lat, e.lat); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] a;
        logic saw_ready;
        a = 32'h0000_7F08;
        @(negedge PClk);
        PrA = a[31:2]; PrBE = 4'b1111; PrWData = 32'h1357_9BDF; PrRW = 1'b1; PrReq = 1'b1;
        @(negedge PClk);
        PrReq = 1'b0;
        @(negedge PClk);
        vectors++; if (DEV_STB !== 4'b0100) begin miscompares++; $display("[TB] FAIL rst_mid_stb_before: got %b expected 0100", DEV_STB); end
        #2 Reset = 1'b1;
        #1;
        vectors++; if (DEV_STB !== 4'b0000) begin miscompares++; $display("[TB] FAIL rst_mid_stb: got %b expected 0000", DEV_STB); end
        vectors++; if (DEV_WE !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_mid_we: got %b expected 0", DEV_WE); end
        @(negedge PClk);
        Reset = 1'b0;
        model_rdata = 32'h0;
        saw_ready = 1'b0;
        repeat (4) begin
            @(negedge PClk);
            if (PrReady) saw_ready = 1'b1;
        end
        vectors++; if (saw_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_mid_no_ready: got %b expected 0", saw_ready); end
        push_expected(32'h0000_7F10, 4'b1111, 32'h0, 1'b0, 3, 1, 32'h0BAD_F00D);
        transact(32'h0000_7F10, 4'b1111, 32'h0, 1'b0, 3, 1, 32'h0BAD_F00D, 1'b0);
        e = sb.pop_front();
        vectors++; if (obs_rdata !== e.rdata) begin miscompares++; $display("[TB] FAIL rst_mid_next_rdata: got %h expected %h", obs_rdata, e.rdata); end
        vectors++; if (obs_lat != e.lat) begin miscompares++; $display("[TB] FAIL rst_mid_next_latency: got %0d expected %0d", obs_lat, e.lat); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] bases [4];
        logic [31:0] offs  [4];
        logic [31:0] addr, wd, dd;
        logic [3:0]  be;
        logic        rw;
        int          ch, wt;
        bases = '{32'h9000_0000, 32'hBFC0_0000, 32'h0000_7F00, 32'h0000_7F10};
        offs  = '{32'h0000_FFFC, 32'h0000_3FFC, 32'h0000_000C, 32'h0000_000C};
        for (int n = 0; n < 10; n++) begin
            ch = $urandom_range(0, 4);
            wt = $urandom_range(0, 3);
            be = 4'($urandom_range(1, 15));
            rw = 1'($urandom_range(0, 1));
            wd = $urandom;
            dd = $urandom;
            if (ch == 4) begin
                addr = 32'h4000_0000 | ($urandom & 32'h0000_FFFC);
                ch = -1;
            end else begin
                addr = bases[ch] | ($urandom & offs[ch]);
            end
            push_expected(addr, be, wd, rw, ch, wt, dd);
            transact(addr, be, wd, rw, ch, wt, dd, 1'b0);
            e = sb.pop_front();
            vectors++; if (obs_rdata !== e.rdata) begin miscompares++; $display("[TB] FAIL b2b_rdata[%0d]: got %h expected %h", n, obs_rdata, e.rdata); end
            vectors++; if (obs_err !== e.err) begin miscompares++; $display("[TB] FAIL b2b_err[%0d]: got %b expected %b", n, obs_err, e.err); end
            vectors++; if (obs_lat != e.lat) begin miscompares++; $display("[TB] FAIL b2b_latency[%0d]: got %0d expected %0d", n, obs_lat, e.lat); end
            vectors++; if (obs_stb !== e.stb) begin miscompares++; $display("[TB] FAIL b2b_stb[%0d]: got %b expected %b", n, obs_stb, e.stb); end
            vectors++; if (obs_adr !== (ch >= 0 ? e.adr : 13'h0)) begin miscompares++; $display("[TB] FAIL b2b_adr[%0d]: got %h expected %h", n, obs_adr, e.adr); end
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_read_dm();
        test_byte_read_im();
        test_write_timer();
        test_unmapped();
        test_timeout();
        test_ack_at_limit();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
